// File: rtl/rx_edge_bit_sampler_if.sv
// rx_edge_bit_sampler_if
//   Bundles the RX FSM <-> bit sampler signals.
//   master : RX FSM side, drives enables, serial input and frame config,
//            observes counters, sampled bit and pulses.
//   slave  : bit sampler side.
//   Signals: cnt_en, dat_samp_en, RX_IN, prescale[PRESCALE_W], frame_bits[BIT_CNT_W]
//            edge_cnt[PRESCALE_W], bit_cnt[BIT_CNT_W], sampled_bit,
//            sample_valid, frame_done, prescale_err
interface rx_edge_bit_sampler_if #(
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4
);
    logic                  cnt_en;
    logic                  dat_samp_en;
    logic                  RX_IN;
    logic [PRESCALE_W-1:0] prescale;
    logic [BIT_CNT_W-1:0]  frame_bits;
    logic [PRESCALE_W-1:0] edge_cnt;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic                  sampled_bit;
    logic                  sample_valid;
    logic                  frame_done;
    logic                  prescale_err;

    modport master (
        output cnt_en, dat_samp_en, RX_IN, prescale, frame_bits,
        input  edge_cnt, bit_cnt, sampled_bit, sample_valid, frame_done, prescale_err
    );

    modport slave (
        input  cnt_en, dat_samp_en, RX_IN, prescale, frame_bits,
        output edge_cnt, bit_cnt, sampled_bit, sample_valid, frame_done, prescale_err
    );
endinterface

// File: rtl/rx_edge_bit_sampler.sv
// rx_edge_bit_sampler
//   UART RX bit timing and data sampling. Counts oversampling edges per bit
//   and bits per frame, takes three samples of RX_IN around mid-bit and
//   majority-votes them into sampled_bit.
//   Ports:
//     clk_RX : oversampling clock
//     rst    : synchronous reset, active-high
//     bus    : rx_edge_bit_sampler_if.slave (enables, RX_IN, prescale,
//              frame_bits in; edge_cnt, bit_cnt, sampled_bit, sample_valid,
//              frame_done, prescale_err out)
module rx_edge_bit_sampler #(
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4
) (
    input  logic                   clk_RX,
    input  logic                   rst,
    rx_edge_bit_sampler_if.slave   bus
);
    localparam logic [PRESCALE_W-1:0] P8  = PRESCALE_W'(8);
    localparam logic [PRESCALE_W-1:0] P16 = PRESCALE_W'(16);
    localparam logic [PRESCALE_W-1:0] P32 = PRESCALE_W'(32);
    localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0] edge_cnt;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic                  s0, s1;
    logic                  sampled_bit;
    logic                  sample_valid;
    logic                  prescale_err;

    logic                  legal;
    logic [PRESCALE_W-1:0] p_eff;
    logic [PRESCALE_W-1:0] mid;
    logic                  last_edge;
    logic                  last_bit;
    logic                  samp_on;

    always_comb begin
        legal = (bus.prescale == P8) || (bus.prescale == P16) || (bus.prescale == P32);
        p_eff = legal ? bus.prescale : P8;
        mid   = p_eff >> 1;
        // >= rather than == so a prescale drop below the current edge
        // closes the bit cleanly instead of running edge_cnt past P-1.
        last_edge = (edge_cnt >= p_eff - ONE);
        last_bit  = (bit_cnt == bus.frame_bits - BIT_CNT_W'(1));
        samp_on   = bus.cnt_en && bus.dat_samp_en;
    end

    // Counters
    always_ff @(posedge clk_RX) begin
        if (rst || !bus.cnt_en) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (last_edge) begin
            edge_cnt <= '0;
            bit_cnt  <= last_bit ? '0 : bit_cnt + BIT_CNT_W'(1);
        end else begin
            edge_cnt <= edge_cnt + ONE;
        end
    end

    // Three mid-bit samples; the vote is taken on the third sample edge so
    // the result appears while edge_cnt == mid+2.
    always_ff @(posedge clk_RX) begin
        if (rst) begin
            s0           <= 1'b0;
            s1           <= 1'b0;
            sampled_bit  <= 1'b1;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (samp_on) begin
                if (edge_cnt == mid - ONE) s0 <= bus.RX_IN;
                if (edge_cnt == mid)       s1 <= bus.RX_IN;
                if (edge_cnt == mid + ONE) begin
                    sampled_bit  <= (s0 & s1) | (s0 & bus.RX_IN) | (s1 & bus.RX_IN);
                    sample_valid <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_RX) begin
        if (rst) prescale_err <= 1'b0;
        else     prescale_err <= !legal;
    end

    assign bus.edge_cnt     = edge_cnt;
    assign bus.bit_cnt      = bit_cnt;
    assign bus.sampled_bit  = sampled_bit;
    assign bus.sample_valid = sample_valid;
    assign bus.prescale_err = prescale_err;
    assign bus.frame_done   = bus.cnt_en && last_edge && last_bit;
endmodule

// File: tb/tb_rx_edge_bit_sampler.sv
module tb_rx_edge_bit_sampler;
    logic clk_RX = 1'b0;
    logic rst    = 1'b0;
    int   checks = 0;
    int   errors = 0;

    rx_edge_bit_sampler_if #(.PRESCALE_W(6), .BIT_CNT_W(4)) bus ();

    rx_edge_bit_sampler #(.PRESCALE_W(6), .BIT_CNT_W(4)) dut (
        .clk_RX (clk_RX),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk_RX = ~clk_RX;

    // Advance one clock; outputs are observed 1 time unit after the edge.
    task automatic tick();
        @(posedge clk_RX);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.cnt_en = 1'b1; bus.dat_samp_en = 1'b1; bus.RX_IN = 1'b0;
        bus.prescale = 6'd8; bus.frame_bits = 4'd10;
        rst = 1'b1;
        tick();
        checks++; if (bus.edge_cnt !== 6'd0) begin errors++; $display("FAIL reset_edge got %0d exp 0", bus.edge_cnt); end
        checks++; if (bus.bit_cnt !== 4'd0) begin errors++; $display("FAIL reset_bit got %0d exp 0", bus.bit_cnt); end
        checks++; if (bus.sampled_bit !== 1'b1) begin errors++; $display("FAIL reset_sampled got %b exp 1", bus.sampled_bit); end
        checks++; if (bus.sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.sample_valid); end
        checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.frame_done); end
        checks++; if (bus.prescale_err !== 1'b0) begin errors++; $display("FAIL reset_perr got %b exp 0", bus.prescale_err); end
        rst = 1'b0;
    endtask

    // P=8, RX_IN=0: vote lands at edge 6 only.
    task automatic test_p8_basic();
        logic [5:0] e;
        bus.prescale = 6'd8; bus.cnt_en = 1'b1; bus.dat_samp_en = 1'b1; bus.RX_IN = 1'b0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            tick();
            e = 6'((i + 1) % 8);
            checks++; if (bus.edge_cnt !== e) begin errors++; $display("FAIL p8_edge i=%0d got %0d exp %0d", i, bus.edge_cnt, e); end
            checks++; if (bus.sample_valid !== (e == 6'd6)) begin errors++; $display("FAIL p8_valid i=%0d got %b exp %b", i, bus.sample_valid, e == 6'd6); end
            checks++; if (bus.sampled_bit !== (i + 1 < 6)) begin errors++; $display("FAIL p8_sampled i=%0d got %b exp %b", i, bus.sampled_bit, i + 1 < 6); end
        end
        checks++; if (bus.bit_cnt !== 4'd1) begin errors++; $display("FAIL p8_bitcnt got %0d exp 1", bus.bit_cnt); end
    endtask

    // Bit 0: single glitch at edge 4 rejected. Bit 1: 1 at edges 4,5 wins.
    task automatic test_glitch();
        bus.prescale = 6'd8; bus.cnt_en = 1'b1; bus.dat_samp_en = 1'b1;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            bus.RX_IN = (i == 4) || (i == 12) || (i == 13);
            tick();
            if (i == 5) begin
                checks++; if (bus.sampled_bit !== 1'b0) begin errors++; $display("FAIL glitch_reject got %b exp 0", bus.sampled_bit); end
                checks++; if (bus.sample_valid !== 1'b1) begin errors++; $display("FAIL glitch_valid0 got %b exp 1", bus.sample_valid); end
            end
            if (i == 13) begin
                checks++; if (bus.sampled_bit !== 1'b1) begin errors++; $display("FAIL glitch_major got %b exp 1", bus.sampled_bit); end
                checks++; if (bus.sample_valid !== 1'b1) begin errors++; $display("FAIL glitch_valid1 got %b exp 1", bus.sample_valid); end
            end
        end
    endtask

    // P=16: 1 only at edges 7..9, so only correct timing yields 1.
    task automatic test_p16();
        logic [5:0] e;
        bus.prescale = 6'd16; bus.cnt_en = 1'b1; bus.dat_samp_en = 1'b1; bus.RX_IN = 1'b0;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            bus.RX_IN = (i >= 7) && (i <= 9);
            tick();
            e = 6'((i + 1) % 16);
            checks++; if (bus.sample_valid !== (e == 6'd10)) begin errors++; $display("FAIL p16_valid i=%0d got %b exp %b", i, bus.sample_valid, e == 6'd10); end
            if (i == 9) begin
                checks++; if (bus.sampled_bit !== 1'b1) begin errors++; $display("FAIL p16_sampled got %b exp 1", bus.sampled_bit); end
            end
        end
        checks++; if (bus.edge_cnt !== 6'd0) begin errors++; $display("FAIL p16_wrap_edge got %0d exp 0", bus.edge_cnt); end
        checks++; if (bus.bit_cnt !== 4'd1) begin errors++; $display("FAIL p16_wrap_bit got %0d exp 1", bus.bit_cnt); end
    endtask

    // Full 10-bit frame at P=8 with sampling disabled.
    task automatic test_frame_done();
        bus.prescale = 6'd8; bus.frame_bits = 4'd10; bus.cnt_en = 1'b1;
        bus.dat_samp_en = 1'b0; bus.RX_IN = 1'b0;
        do_reset();
        for (int i = 0; i < 80; i++) begin
            checks++; if (bus.frame_done !== (i == 79)) begin errors++; $display("FAIL frame_done i=%0d got %b exp %b", i, bus.frame_done, i == 79); end
            checks++; if (bus.sample_valid !== 1'b0) begin errors++; $display("FAIL nosamp_valid i=%0d got %b exp 0", i, bus.sample_valid); end
            if (i == 79) begin
                checks++; if (bus.bit_cnt !== 4'd9) begin errors++; $display("FAIL frame_lastbit got %0d exp 9", bus.bit_cnt); end
                checks++; if (bus.edge_cnt !== 6'd7) begin errors++; $display("FAIL frame_lastedge got %0d exp 7", bus.edge_cnt); end
            end
            tick();
        end
        checks++; if (bus.bit_cnt !== 4'd0) begin errors++; $display("FAIL frame_wrap_bit got %0d exp 0", bus.bit_cnt); end
        checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL frame_done_after got %b exp 0", bus.frame_done); end
        checks++; if (bus.sampled_bit !== 1'b1) begin errors++; $display("FAIL nosamp_hold got %b exp 1", bus.sampled_bit); end
    endtask

    // Illegal prescale falls back to 8.
    task automatic test_prescale_err();
        logic [5:0] e;
        bus.prescale = 6'd8; bus.cnt_en = 1'b1; bus.dat_samp_en = 1'b1; bus.RX_IN = 1'b0;
        do_reset();
        bus.prescale = 6'd12;
        for (int i = 0; i < 8; i++) begin
            tick();
            e = 6'((i + 1) % 8);
            checks++; if (bus.prescale_err !== 1'b1) begin errors++; $display("FAIL perr_flag i=%0d got %b exp 1", i, bus.prescale_err); end
            checks++; if (bus.sample_valid !== (e == 6'd6)) begin errors++; $display("FAIL perr_valid i=%0d got %b exp %b", i, bus.sample_valid, e == 6'd6); end
        end
        checks++; if (bus.bit_cnt !== 4'd1) begin errors++; $display("FAIL perr_wrap got %0d exp 1", bus.bit_cnt); end
        bus.prescale = 6'd8;
        tick();
        checks++; if (bus.prescale_err !== 1'b0) begin errors++; $display("FAIL perr_clear got %b exp 0", bus.prescale_err); end
    endtask

    // Drop from P=32 to P=16 with edge_cnt already past 15.
    task automatic test_prescale_change();
        bus.prescale = 6'd32; bus.cnt_en = 1'b1; bus.dat_samp_en = 1'b0; bus.RX_IN = 1'b1;
        do_reset();
        for (int i = 0; i < 21; i++) tick();
        checks++; if (bus.edge_cnt !== 6'd21) begin errors++; $display("FAIL pchg_pre got %0d exp 21", bus.edge_cnt); end
        bus.prescale = 6'd16;
        tick();
        checks++; if (bus.edge_cnt !== 6'd0) begin errors++; $display("FAIL pchg_edge got %0d exp 0", bus.edge_cnt); end
        checks++; if (bus.bit_cnt !== 4'd1) begin errors++; $display("FAIL pchg_bit got %0d exp 1", bus.bit_cnt); end
        tick();
        checks++; if (bus.edge_cnt !== 6'd1) begin errors++; $display("FAIL pchg_next got %0d exp 1", bus.edge_cnt); end
    endtask

    task automatic test_cnt_en_off();
        bus.prescale = 6'd8; bus.cnt_en = 1'b1; bus.dat_samp_en = 1'b1; bus.RX_IN = 1'b0;
        do_reset();
        for (int i = 0; i < 7; i++) tick();
        bus.cnt_en = 1'b0;
        tick();
        checks++; if (bus.edge_cnt !== 6'd0) begin errors++; $display("FAIL cnten_edge got %0d exp 0", bus.edge_cnt); end
        checks++; if (bus.sampled_bit !== 1'b0) begin errors++; $display("FAIL cnten_hold got %b exp 0", bus.sampled_bit); end
        bus.RX_IN = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        checks++; if (bus.edge_cnt !== 6'd0) begin errors++; $display("FAIL cnten_stay got %0d exp 0", bus.edge_cnt); end
        checks++; if (bus.sample_valid !== 1'b0) begin errors++; $display("FAIL cnten_valid got %b exp 0", bus.sample_valid); end
        checks++; if (bus.sampled_bit !== 1'b0) begin errors++; $display("FAIL cnten_hold2 got %b exp 0", bus.sampled_bit); end
    endtask

    // Reset lands on the edge that would otherwise produce a vote.
    task automatic test_reset_mid();
        bus.prescale = 6'd8; bus.frame_bits = 4'd10; bus.cnt_en = 1'b1;
        bus.dat_samp_en = 1'b1; bus.RX_IN = 1'b0;
        do_reset();
        for (int i = 0; i < 29; i++) tick();
        checks++; if (bus.bit_cnt !== 4'd3 || bus.edge_cnt !== 6'd5) begin errors++; $display("FAIL rmid_pos got %0d/%0d exp 3/5", bus.bit_cnt, bus.edge_cnt); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus.edge_cnt !== 6'd0) begin errors++; $display("FAIL rmid_edge got %0d exp 0", bus.edge_cnt); end
        checks++; if (bus.bit_cnt !== 4'd0) begin errors++; $display("FAIL rmid_bit got %0d exp 0", bus.bit_cnt); end
        checks++; if (bus.sample_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b exp 0", bus.sample_valid); end
        checks++; if (bus.sampled_bit !== 1'b1) begin errors++; $display("FAIL rmid_sampled got %b exp 1", bus.sampled_bit); end
        checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL rmid_done got %b exp 0", bus.frame_done); end
    endtask

    initial begin
        test_reset();
        test_p8_basic();
        test_glitch();
        test_p16();
        test_frame_done();
        test_prescale_err();
        test_prescale_change();
        test_cnt_en_off();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
